// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding
// and the parity-type codes carried on req_parity / tx_parity.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Parity type codes; code 3 is also treated as "none" by the transmitter.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found when scanning upward from rr_ptr and wrapping at NUM_REQ.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]     sum  [NUM_REQ];
  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // Candidate gi is the requester sitting gi places after the pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum[gi] >= N_EXT) ? IDX_W'(sum[gi] - N_EXT)
                                           : IDX_W'(sum[gi]);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Nearest candidate wins: scan from farthest to nearest, last hit overrides.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters access to a shared
// UART transmitter. Latches the winner's payload and parity, fires a single
// tx_send, waits for tx_done (or aborts after TIMEOUT_CYCLES WAIT cycles),
// then acks the winner and advances the round-robin pointer past it.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 5224
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ*2-1:0]           req_parity,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           timeout_err,
  output logic                           tx_send,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic [1:0]                     tx_parity,
  input  logic                           tx_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [IDX_W-1:0]     grant_id_reg;
  logic [DATA_BITS-1:0] tx_data_reg;
  logic [1:0]           tx_parity_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 timeout_err_reg;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 timeout_hit;

  logic [DATA_BITS-1:0] data_slice [NUM_REQ];
  logic [1:0]           par_slice  [NUM_REQ];

  // Unpack the flat per-requester buses so the winner can be indexed directly.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_slice[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
      assign par_slice[gi]  = req_parity[gi*2 +: 2];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign timeout_hit = (cnt_reg == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; tx_done is only looked at in WAIT and beats the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (pick_valid) state_next = ST_SEND;
      ST_SEND:    state_next = ST_WAIT;
      ST_WAIT:    if (tx_done || timeout_hit) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: busy, the single send strobe and the ack pulse.
  always_comb begin
    busy    = (state_reg != ST_IDLE);
    tx_send = (state_reg == ST_SEND);
    ack     = '0;
    if (state_reg == ST_RELEASE) begin
      ack[grant_id_reg] = 1'b1;
    end
  end

  // Grant latch, WAIT counter, timeout flag and round-robin pointer update.
  // The latched payload only changes on a new grant so the transmitter can
  // sample it for the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg      <= '0;
      grant_id_reg    <= '0;
      tx_data_reg     <= '0;
      tx_parity_reg   <= PAR_NONE;
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id_reg  <= pick_idx;
            tx_data_reg   <= data_slice[pick_idx];
            tx_parity_reg <= par_slice[pick_idx];
          end
        end
        ST_SEND: begin
          cnt_reg <= '0;
        end
        ST_WAIT: begin
          if (cnt_reg != CNT_SAT) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (timeout_hit && !tx_done) begin
            timeout_err_reg <= 1'b1;
          end
        end
        ST_RELEASE: begin
          rr_ptr_reg <= (grant_id_reg == IDX_LAST) ? '0 : grant_id_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant_id    = grant_id_reg;
  assign tx_data     = tx_data_reg;
  assign tx_parity   = tx_parity_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Two instances share stimulus:
// dut_a uses a long timeout for normal frames, dut_b a 10-cycle timeout for
// abort cases. sel routes req/tx_done to one instance and picks its outputs.
module tb_uart_tx_arbiter;

  localparam int T_A = 64;
  localparam int T_B = 10;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [3:0]  req_v;
  logic        done_v;
  logic [31:0] req_data;
  logic [7:0]  req_parity;

  logic [3:0] req_a, req_b;
  logic       done_a, done_b;

  logic [3:0] a_ack, b_ack;
  logic       a_busy, b_busy;
  logic [1:0] a_gid, b_gid;
  logic       a_to, b_to;
  logic       a_send, b_send;
  logic [7:0] a_data, b_data;
  logic [1:0] a_par, b_par;

  logic [3:0] o_ack;
  logic       o_busy, o_to, o_send;
  logic [1:0] o_gid, o_par;
  logic [7:0] o_data;

  int n_tests = 0;
  int n_fail  = 0;
  int model_ptr [2];

  assign req_a  = sel ? 4'b0 : req_v;
  assign req_b  = sel ? req_v : 4'b0;
  assign done_a = !sel && done_v;
  assign done_b = sel && done_v;

  assign o_ack  = sel ? b_ack  : a_ack;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_gid  = sel ? b_gid  : a_gid;
  assign o_to   = sel ? b_to   : a_to;
  assign o_send = sel ? b_send : a_send;
  assign o_data = sel ? b_data : a_data;
  assign o_par  = sel ? b_par  : a_par;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT_CYCLES(T_A)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_data(req_data), .req_parity(req_parity),
    .ack(a_ack), .busy(a_busy), .grant_id(a_gid), .timeout_err(a_to),
    .tx_send(a_send), .tx_data(a_data), .tx_parity(a_par), .tx_done(done_a)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT_CYCLES(T_B)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_data(req_data), .req_parity(req_parity),
    .ack(b_ack), .busy(b_busy), .grant_id(b_gid), .timeout_err(b_to),
    .tx_send(b_send), .tx_data(b_data), .tx_parity(b_par), .tx_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference winner: first requester at or after ptr, wrapping modulo 4.
  function automatic int model_pick(input logic [3:0] m, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (m[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // Idle cycles with no request and stray tx_done pulses that must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_v  = 4'b0;
      done_v = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("idle", "busy", 32'(o_busy), 0);
      check("idle", "ack", 32'(o_ack), 0);
    end
    done_v = 1'b0;
  endtask

  // One arbitration round, entered and left at an IDLE sampling point.
  // delay: WAIT cycle (1-based) carrying tx_done; outside 1..T means never.
  // abort_at: WAIT cycle at which rst is asserted mid-cycle (0 = none).
  task automatic do_txn(input logic [3:0] mask, input int delay,
                        input int abort_at, input string tag);
    int t, win, endw;
    logic [7:0] ed;
    logic [1:0] ep;
    logic to_exp;
    t   = sel ? T_B : T_A;
    win = model_pick(mask, model_ptr[sel]);
    ed  = req_data[win*8 +: 8];
    ep  = req_parity[win*2 +: 2];
    if (delay >= 1 && delay <= t) begin
      endw = delay; to_exp = 1'b0;
    end else begin
      endw = t; to_exp = 1'b1;
    end

    check(tag, "idle_busy", 32'(o_busy), 0);
    req_v  = mask;
    done_v = 1'($urandom_range(0, 1));
    @(posedge clk); #1;

    // SEND cycle: one cycle after the request was sampled.
    check(tag, "send", 32'(o_send), 1);
    check(tag, "send_busy", 32'(o_busy), 1);
    check(tag, "grant", 32'(o_gid), 32'(win));
    check(tag, "data", 32'(o_data), 32'(ed));
    check(tag, "parity", 32'(o_par), 32'(ep));
    check(tag, "send_ack", 32'(o_ack), 0);
    done_v     = 1'($urandom_range(0, 1));
    req_v      = 4'($urandom);
    req_data   = $urandom;
    req_parity = 8'($urandom);
    @(posedge clk); #1;

    for (int w = 1; w <= endw; w++) begin
      check(tag, "wait_send", 32'(o_send), 0);
      check(tag, "wait_ack", 32'(o_ack), 0);
      check(tag, "wait_to", 32'(o_to), 0);
      check(tag, "wait_data", 32'(o_data), 32'(ed));
      check(tag, "wait_par", 32'(o_par), 32'(ep));
      check(tag, "wait_grant", 32'(o_gid), 32'(win));
      if (w == abort_at) begin
        #3 rst = 1'b1;
        #1;
        check(tag, "rst_busy", 32'(o_busy), 0);
        check(tag, "rst_send", 32'(o_send), 0);
        check(tag, "rst_data", 32'(o_data), 0);
        check(tag, "rst_par", 32'(o_par), 0);
        check(tag, "rst_ack", 32'(o_ack), 0);
        check(tag, "rst_grant", 32'(o_gid), 0);
        check(tag, "rst_to", 32'(o_to), 0);
        done_v = 1'b0;
        req_v  = 4'b0;
        @(posedge clk); #1;
        check(tag, "rst_ack2", 32'(o_ack), 0);
        rst = 1'b0;
        model_ptr[0] = 0;
        model_ptr[1] = 0;
        @(posedge clk); #1;
        check(tag, "post_rst_ack", 32'(o_ack), 0);
        check(tag, "post_rst_busy", 32'(o_busy), 0);
        $display("[TB] %s: dut=%0d mask=%b grant=%0d aborted by reset", tag, sel, mask, win);
        return;
      end
      done_v     = (w == delay);
      req_v      = 4'($urandom);
      req_data   = $urandom;
      if (w == 2) req_data[win*8 +: 8] = 8'h00;
      req_parity = 8'($urandom);
      @(posedge clk); #1;
    end

    // RELEASE cycle.
    check(tag, "ack", 32'(o_ack), 32'(1) << win);
    check(tag, "timeout", 32'(o_to), 32'(to_exp));
    check(tag, "rel_busy", 32'(o_busy), 1);
    check(tag, "rel_send", 32'(o_send), 0);
    model_ptr[sel] = (win + 1) % 4;
    req_v  = 4'b0;
    done_v = 1'($urandom_range(0, 1));
    @(posedge clk); #1;

    // Back in IDLE: payload still held until the next grant.
    check(tag, "end_busy", 32'(o_busy), 0);
    check(tag, "end_ack", 32'(o_ack), 0);
    check(tag, "end_to", 32'(o_to), 0);
    check(tag, "end_data", 32'(o_data), 32'(ed));
    check(tag, "end_grant", 32'(o_gid), 32'(win));
    done_v = 1'b0;
    $display("[TB] %s: dut=%0d mask=%b grant=%0d data=%h parity=%0d timeout=%0b",
             tag, sel, mask, win, ed, ep, to_exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [3:0] m;
    sel = 1'b0; req_v = 4'b0; done_v = 1'b0;
    req_data = '0; req_parity = '0; rst = 1'b1;
    model_ptr[0] = 0;
    model_ptr[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "busy", 32'(o_busy), 0);
    check("reset", "send", 32'(o_send), 0);
    check("reset", "data", 32'(o_data), 0);
    check("reset", "parity", 32'(o_par), 0);
    check("reset", "ack", 32'(o_ack), 0);
    check("reset", "grant", 32'(o_gid), 0);
    check("reset", "timeout", 32'(o_to), 0);
    check("reset", "b_busy", 32'(b_busy), 0);
    rst = 1'b0;
    idle_cycles(3);

    // Single request, done at WAIT cycle 20.
    req_data = $urandom; req_data[7:0] = 8'hA5;
    req_parity = 8'($urandom); req_parity[1:0] = 2'd2;
    do_txn(4'b0001, 20, 0, "basic");
    // Pointer now 1: requester 1 must beat requester 0.
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b0011, 5, 0, "ptr1");
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b1100, 3, 0, "ptr2");
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b1000, 1, 0, "ptr3");

    // Fairness: all held high, expect 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      req_data = $urandom; req_parity = 8'($urandom);
      do_txn(4'b1111, $urandom_range(1, 8), 0, $sformatf("fair%0d", i));
    end

    // Payload changed to 00 mid-WAIT must not reach tx_data.
    req_data = $urandom; req_data[23:16] = 8'h5A; req_parity = 8'($urandom);
    do_txn(4'b0100, 12, 0, "hold2");

    // Short-timeout instance: abort, coincident done, just-in-time done.
    sel = 1'b1;
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b0010, 0, 0, "timeout");
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b0001, T_B, 0, "coincide");
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b1001, T_B - 1, 0, "justin");
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b0110, T_B + 1, 0, "late");

    // Reset during WAIT, then a fresh request from pointer 0.
    sel = 1'b0;
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b0001, 30, 4, "rstwait");
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b0100, 6, 0, "postrst");
    req_data = $urandom; req_parity = 8'($urandom);
    do_txn(4'b1111, 2, 0, "postrst2");

    // Randomized rounds on both instances.
    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom_range(0, 1));
      t = sel ? T_B : T_A;
      m = 4'($urandom_range(1, 15));
      req_data = $urandom;
      req_parity = 8'($urandom);
      do_txn(m, $urandom_range(1, t + 3), 0, $sformatf("rnd%0d", i));
      idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
